// File: rtl/dot_matrix_pkg.sv
// Shared types and helpers for the dot-matrix cursor block.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package dot_matrix_pkg;

  // Power/display sequencing states.
  typedef enum logic [1:0] {
    OFF  = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Direction codes over the button vector {left,down,right,up}.
  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_RIGHT = 4'b0010;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  // A button vector is a command only when exactly one button is pressed.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

endpackage

// File: rtl/dot_matrix_cursor_if.sv
// Button inputs and LED/cursor outputs of the dot-matrix cursor block.
// Latency: n/a (wiring only).
// Backpressure: none; buttons are level inputs and outputs are always valid.
interface dot_matrix_cursor_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  localparam int RW = ($clog2(ROWS) < 1) ? 1 : $clog2(ROWS);
  localparam int CW = ($clog2(COLS) < 1) ? 1 : $clog2(COLS);

  logic                 power;
  logic                 up;
  logic                 down;
  logic                 right;
  logic                 left;
  logic [ROWS*COLS-1:0] frame;
  logic [RW-1:0]        cur_row;
  logic [CW-1:0]        cur_col;
  logic                 moved;
  logic [ROWS-1:0]      scan_row_sel;
  logic [COLS-1:0]      scan_col_data;

  // Button front end / stimulus side.
  modport master (
    output power, up, down, right, left,
    input  frame, cur_row, cur_col, moved, scan_row_sel, scan_col_data
  );

  // Cursor block side.
  modport slave (
    input  power, up, down, right, left,
    output frame, cur_row, cur_col, moved, scan_row_sel, scan_col_data
  );

endinterface

// File: rtl/dm_key_repeat.sv
// Decodes one-hot direction commands and produces move strobes with hold-to-repeat.
// Latency: step is combinational from the sampled buttons (acts at the same edge).
// Backpressure: none; en low discards commands and restarts repeat timing.
module dm_key_repeat
  import dot_matrix_pkg::*;
#(
  parameter int REPEAT_DLY  = 8,
  parameter int REPEAT_RATE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] dir_in,
  output logic       step,
  output logic [3:0] step_dir
);
  localparam int RMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int CNTW = $clog2(RMAX + 1);

  logic [3:0]      prev_q, prev_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            rep_q, rep_d;

  // Fire on a fresh command, then after REPEAT_DLY, then every REPEAT_RATE while held.
  always_comb begin
    prev_d   = 4'b0000;
    cnt_d    = '0;
    rep_d    = 1'b0;
    step     = 1'b0;
    step_dir = 4'b0000;
    if (en && is_onehot4(dir_in)) begin
      prev_d   = dir_in;
      step_dir = dir_in;
      if (dir_in != prev_q) begin
        step  = 1'b1;
        cnt_d = CNTW'(1);
      end else if ((!rep_q && cnt_q == CNTW'(REPEAT_DLY)) ||
                   ( rep_q && cnt_q == CNTW'(REPEAT_RATE))) begin
        step  = 1'b1;
        cnt_d = CNTW'(1);
        rep_d = 1'b1;
      end else begin
        rep_d = rep_q;
        // Saturate rather than wrap so a stale count can never alias a fire point.
        cnt_d = (cnt_q == CNTW'(RMAX)) ? cnt_q : cnt_q + 1'b1;
      end
    end
  end

  // Previous command, repeat counter and repeat phase registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 4'b0000;
      cnt_q  <= '0;
      rep_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      rep_q  <= rep_d;
    end
  end

endmodule

// File: rtl/dot_matrix_cursor.sv
// Single-lit cursor on a ROWS x COLS LED matrix with power sequencing and row-scan drive.
// Latency: one cycle from sampled button to cursor/frame/moved outputs.
// Backpressure: none; commands outside RUN or with power low are discarded.
module dot_matrix_cursor
  import dot_matrix_pkg::*;
#(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter bit WRAP        = 1'b1,
  parameter int REPEAT_DLY  = 8,
  parameter int REPEAT_RATE = 4,
  parameter int SCAN_DIV    = 2
) (
  input  logic               clk,
  input  logic               reset,
  dot_matrix_cursor_if.slave bus
);
  localparam int RW = ($clog2(ROWS) < 1) ? 1 : $clog2(ROWS);
  localparam int CW = ($clog2(COLS) < 1) ? 1 : $clog2(COLS);
  localparam int SW = ($clog2(SCAN_DIV) < 1) ? 1 : $clog2(SCAN_DIV);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  state_t          state_q, state_d;
  logic [RW-1:0]   row_q, row_d, row_n;
  logic [CW-1:0]   col_q, col_d, col_n;
  logic            moved_q, moved_d;
  logic [SW-1:0]   div_q, div_d;
  logic [RW-1:0]   idx_q, idx_d;
  logic            key_en;
  logic            step;
  logic [3:0]      step_dir;
  logic            display_on;
  logic [ROWS*COLS-1:0] frame_w;
  logic [ROWS-1:0] sel_w;
  logic [COLS-1:0] data_w;

  assign key_en = (state_q == RUN) && bus.power;

  dm_key_repeat #(
    .REPEAT_DLY  (REPEAT_DLY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_key (
    .clk      (clk),
    .reset    (reset),
    .en       (key_en),
    .dir_in   ({bus.left, bus.down, bus.right, bus.up}),
    .step     (step),
    .step_dir (step_dir)
  );

  // Power sequencing: OFF -> INIT -> RUN, with power low forcing OFF from anywhere.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OFF:     if (bus.power) state_d = INIT;
      INIT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = OFF;
    endcase
    if (!bus.power) state_d = OFF;
  end

  // Candidate position for the requested direction; edges compare against the last index explicitly.
  always_comb begin
    row_n = row_q;
    col_n = col_q;
    if (step_dir == DIR_UP) begin
      if (row_q == '0) row_n = WRAP ? ROW_LAST : row_q;
      else             row_n = row_q - 1'b1;
    end else if (step_dir == DIR_DOWN) begin
      if (row_q == ROW_LAST) row_n = WRAP ? '0 : row_q;
      else                   row_n = row_q + 1'b1;
    end else if (step_dir == DIR_LEFT) begin
      if (col_q == '0) col_n = WRAP ? COL_LAST : col_q;
      else             col_n = col_q - 1'b1;
    end else if (step_dir == DIR_RIGHT) begin
      if (col_q == COL_LAST) col_n = WRAP ? '0 : col_q;
      else                   col_n = col_q + 1'b1;
    end
  end

  // Cursor only moves while staying in RUN; every other path parks it at (0,0).
  always_comb begin
    row_d   = '0;
    col_d   = '0;
    moved_d = 1'b0;
    if (state_q == RUN && state_d == RUN) begin
      row_d = row_q;
      col_d = col_q;
      if (step) begin
        row_d   = row_n;
        col_d   = col_n;
        moved_d = (row_n != row_q) || (col_n != col_q);
      end
    end
  end

  // Scan divider and row index run only while the display is and stays on.
  always_comb begin
    div_d = '0;
    idx_d = '0;
    if (state_q != OFF && state_d != OFF) begin
      idx_d = idx_q;
      if (div_q == SW'(SCAN_DIV - 1)) begin
        idx_d = (idx_q == ROW_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  // State, cursor, moved pulse and scan counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= OFF;
      row_q   <= '0;
      col_q   <= '0;
      moved_q <= 1'b0;
      div_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      moved_q <= moved_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
    end
  end

  assign display_on = (state_q != OFF);

  // One-hot image at the cursor and the row slice currently being scanned.
  always_comb begin
    frame_w = '0;
    sel_w   = '0;
    data_w  = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        frame_w[r*COLS + c] = display_on && (row_q == RW'(r)) && (col_q == CW'(c));
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      if (display_on && idx_q == RW'(r)) begin
        sel_w[r] = 1'b1;
        data_w   = frame_w[r*COLS +: COLS];
      end
    end
  end

  assign bus.frame         = frame_w;
  assign bus.cur_row       = row_q;
  assign bus.cur_col       = col_q;
  assign bus.moved         = moved_q;
  assign bus.scan_row_sel  = sel_w;
  assign bus.scan_col_data = data_w;

endmodule

// File: tb/tb_dot_matrix_cursor.sv
// Directed bench: 4x4 wrapping instance (table + sequences) and 3x5 clamping instance (scan).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_dot_matrix_cursor;
  import dot_matrix_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  dot_matrix_cursor_if #(.ROWS(4), .COLS(4)) a_if ();
  dot_matrix_cursor_if #(.ROWS(3), .COLS(5)) b_if ();

  dot_matrix_cursor #(
    .ROWS(4), .COLS(4), .WRAP(1'b1), .REPEAT_DLY(8), .REPEAT_RATE(4), .SCAN_DIV(2)
  ) u_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (a_if.slave)
  );

  dot_matrix_cursor #(
    .ROWS(3), .COLS(5), .WRAP(1'b0), .REPEAT_DLY(2), .REPEAT_RATE(1), .SCAN_DIV(2)
  ) u_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (b_if.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        pwr;
    logic [3:0]  btn;   // {left,down,right,up}
    logic [1:0]  row;
    logic [1:0]  col;
    logic        mv;
    logic [15:0] frame;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic p, input logic [3:0] b, input logic [1:0] r,
                     input logic [1:0] c, input logic m, input logic [15:0] f);
    vec_t v;
    v.pwr = p; v.btn = b; v.row = r; v.col = c; v.mv = m; v.frame = f;
    tbl.push_back(v);
  endtask

  task automatic drive_a(input logic p, input logic [3:0] b);
    a_if.power = p;
    {a_if.left, a_if.down, a_if.right, a_if.up} = b;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic p, input logic [3:0] b);
    b_if.power = p;
    {b_if.left, b_if.down, b_if.right, b_if.up} = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [1:0] r, input logic [1:0] c,
                         input logic m, input logic [15:0] f);
    chk({tag, ".row"},   a_if.cur_row, r);
    chk({tag, ".col"},   a_if.cur_col, c);
    chk({tag, ".moved"}, a_if.moved, m);
    chk({tag, ".frame"}, a_if.frame, f);
  endtask

  task automatic check_b(input string tag, input logic [1:0] r, input logic [2:0] c, input logic m);
    chk({tag, ".row"},   b_if.cur_row, r);
    chk({tag, ".col"},   b_if.cur_col, c);
    chk({tag, ".moved"}, b_if.moved, m);
  endtask

  initial begin
    logic [1:0] exp_row;
    logic       exp_mv;
    logic [2:0] exp_sel [6];
    logic [4:0] exp_dat [6];
    bit         found;

    rst_a = 1'b1; rst_b = 1'b1;
    a_if.power = 1'b0; {a_if.left, a_if.down, a_if.right, a_if.up} = 4'b0000;
    b_if.power = 1'b0; {b_if.left, b_if.down, b_if.right, b_if.up} = 4'b0000;

    // Table for the 4x4 wrapping instance, applied right after reset.
    add(1, 4'b0000, 0, 0, 0, 16'h0001);   // INIT
    add(1, 4'b0000, 0, 0, 0, 16'h0001);   // RUN
    add(1, 4'b0000, 0, 0, 0, 16'h0001);
    add(1, 4'b0001, 3, 0, 1, 16'h1000);   // up wraps to row 3
    add(1, 4'b0000, 3, 0, 0, 16'h1000);
    for (int i = 0; i < 5; i++) add(1, 4'b0110, 3, 0, 0, 16'h1000);  // down+right: no command
    add(1, 4'b0010, 3, 1, 1, 16'h2000);   // right alone moves at once
    add(1, 4'b0000, 3, 1, 0, 16'h2000);
    add(1, 4'b1000, 3, 0, 1, 16'h1000);   // left
    add(1, 4'b1000, 3, 0, 0, 16'h1000);   // held, before first repeat
    add(1, 4'b0000, 3, 0, 0, 16'h1000);
    add(1, 4'b0100, 0, 0, 1, 16'h0001);   // down wraps to row 0
    add(1, 4'b0000, 0, 0, 0, 16'h0001);

    // Reset state of both instances.
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_a("rst_a", 0, 0, 0, 16'h0000);
    chk("rst_a.sel", a_if.scan_row_sel, 4'b0000);
    chk("rst_a.dat", a_if.scan_col_data, 4'b0000);
    chk("rst_b.frame", b_if.frame, 15'h0000);
    chk("rst_b.sel", b_if.scan_row_sel, 3'b000);

    rst_a = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      drive_a(tbl[i].pwr, tbl[i].btn);
      check_a($sformatf("vec%0d", i), tbl[i].row, tbl[i].col, tbl[i].mv, tbl[i].frame);
      if (i == 2) chk("state_run", u_a.state_q, RUN);
    end

    // Down held 20 cycles from (0,0): moves at 0, 8, 12, 16.
    for (int k = 0; k < 20; k++) begin
      drive_a(1, 4'b0100);
      exp_mv  = (k == 0) || (k == 8) || (k == 12) || (k == 16);
      exp_row = (k < 8) ? 2'd1 : (k < 12) ? 2'd2 : (k < 16) ? 2'd3 : 2'd0;
      chk($sformatf("hold%0d.row", k), a_if.cur_row, exp_row);
      chk($sformatf("hold%0d.moved", k), a_if.moved, exp_mv);
    end
    drive_a(1, 4'b0000);
    check_a("release", 0, 0, 0, 16'h0001);

    // Power drop while a move is requested: move discarded, everything off.
    drive_a(1, 4'b0010);
    check_a("pre_drop", 0, 1, 1, 16'h0002);
    drive_a(0, 4'b0100);
    check_a("pwr_off", 0, 0, 0, 16'h0000);
    chk("pwr_off.sel", a_if.scan_row_sel, 4'b0000);
    drive_a(1, 4'b0000);
    check_a("pwr_init", 0, 0, 0, 16'h0001);
    chk("pwr_init.state", u_a.state_q, INIT);
    drive_a(1, 4'b0000);
    chk("pwr_run.state", u_a.state_q, RUN);

    // Reset in RUN returns to OFF, then INIT restarts at (0,0).
    drive_a(1, 4'b0100);
    check_a("pre_rst", 1, 0, 1, 16'h0010);
    rst_a = 1'b1;
    drive_a(1, 4'b0100);
    check_a("mid_rst", 0, 0, 0, 16'h0000);
    chk("mid_rst.state", u_a.state_q, OFF);
    rst_a = 1'b0;
    drive_a(1, 4'b0000);
    check_a("rst_init", 0, 0, 0, 16'h0001);
    chk("rst_init.state", u_a.state_q, INIT);

    // 3x5 clamping instance: walk to the right edge, then try to pass it.
    rst_b = 1'b0;
    drive_b(1, 4'b0000);
    drive_b(1, 4'b0000);
    for (int i = 1; i <= 4; i++) begin
      drive_b(1, 4'b0010);
      check_b($sformatf("b_right%0d", i), 0, 3'(i), 1);
      drive_b(1, 4'b0000);
    end
    drive_b(1, 4'b0010);
    check_b("b_clamp_right", 0, 4, 0);
    drive_b(1, 4'b0000);
    drive_b(1, 4'b0001);
    check_b("b_clamp_up", 0, 4, 0);
    drive_b(1, 4'b0000);
    drive_b(1, 4'b0100);
    check_b("b_down1", 1, 4, 1);
    drive_b(1, 4'b0000);
    drive_b(1, 4'b0100);
    check_b("b_down2", 2, 4, 1);
    drive_b(1, 4'b0000);
    drive_b(1, 4'b0100);
    check_b("b_clamp_down", 2, 4, 0);
    drive_b(1, 4'b0000);
    chk("b_frame", b_if.frame, 15'h4000);

    // Scan: lock onto the first row-0 cycle after row 2, then check a full period.
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (b_if.scan_row_sel == 3'b100) found = 1'b1;
      else drive_b(1, 4'b0000);
    end
    chk("scan_find_row2", found, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      drive_b(1, 4'b0000);
      if (b_if.scan_row_sel != 3'b100) found = 1'b1;
    end
    chk("scan_leave_row2", found, 1'b1);
    chk("scan0.sel", b_if.scan_row_sel, 3'b001);
    chk("scan0.dat", b_if.scan_col_data, 5'b00000);
    exp_sel = '{3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
    exp_dat = '{5'b00000, 5'b00000, 5'b00000, 5'b10000, 5'b10000, 5'b00000};
    for (int i = 0; i < 6; i++) begin
      drive_b(1, 4'b0000);
      chk($sformatf("scan%0d.sel", i + 1), b_if.scan_row_sel, exp_sel[i]);
      chk($sformatf("scan%0d.dat", i + 1), b_if.scan_col_data, exp_dat[i]);
    end

    // Power off: all outputs zero after the next edge.
    drive_b(0, 4'b0000);
    check_b("b_off", 0, 0, 0);
    chk("b_off.frame", b_if.frame, 15'h0000);
    chk("b_off.sel", b_if.scan_row_sel, 3'b000);
    chk("b_off.dat", b_if.scan_col_data, 5'b00000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dot_matrix_cursor.md
# dot_matrix_cursor

Parametrised successor to the team's 4x4 dot-matrix cursor block. It drives a single-lit cursor on a ROWS x COLS LED matrix from four direction buttons, with power/reset sequencing. It adds configurable edge behaviour (wrap or clamp), hold-to-repeat auto-movement, and a time-multiplexed row-scan drive for physical matrices. It sits between the debounced button front end and the LED driver pins.

## Interface
- ROWS, 4, matrix rows (>=2)
- COLS, 4, matrix columns (>=2)
- WRAP, 1, 1 = cursor wraps at edges; 0 = cursor clamps at edges
- REPEAT_DLY, 8, cycles a direction must be held before the first auto-repeat move (>=1)
- REPEAT_RATE, 4, cycles between subsequent auto-repeat moves (>=1)
- SCAN_DIV, 2, clk cycles per scanned row (>=1)
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  synchronous, active-high
- power  in  1  1 = display on; 0 = forced OFF
- up, down, right, left  in  1 each  direction buttons, already synchronous to clk and debounced upstream
- frame  out  ROWS*COLS  full image; bit r*COLS+c = LED (r,c)
- cur_row  out  RW=max(1,$clog2(ROWS))  cursor row
- cur_col  out  CW=max(1,$clog2(COLS))  cursor column
- moved  out  1  one-cycle pulse when the cursor position changes
- scan_row_sel  out  ROWS  one-hot active row for multiplexed drive
- scan_col_data  out  COLS  column data for the active row

## Operation
- States: OFF, INIT, RUN.
- reset=1: state<=OFF. Cursor, repeat counter, scan counter, and previous-direction register all go to 0. All outputs are 0 during the following cycle.
- Any state with power=0 goes to OFF (takes priority over all transitions except reset).
- OFF with power=1 goes to INIT. INIT loads cursor (0,0) and goes to RUN unconditionally.
- Command decode: {left,down,right,up} is valid only when exactly one bit is set. Zero or multiple bits mean no command; the repeat counter clears and no move occurs.
- Moves:
  - up: row-1
  - down: row+1
  - left: col-1
  - right: col+1
- Edge handling: with WRAP=1, row 0 up gives ROWS-1, row ROWS-1 down gives 0, and columns behave the same way. With WRAP=0, the cursor stays at the edge and moved stays 0.
- Moves are accepted only in RUN.
  - A move fires on the first cycle a valid command differs from the previous cycle's command.
  - If the same valid command is still held, the first repeat fires REPEAT_DLY cycles after the initial move.
  - Further repeats fire every REPEAT_RATE cycles after that.
  - Changing to a different valid command moves immediately and restarts the repeat timing.
- frame is one-hot at the cursor position in INIT and RUN, and all-zero in OFF.
- Scan:
  - In INIT and RUN, the scan row index advances every SCAN_DIV cycles through 0..ROWS-1 and wraps.
  - scan_row_sel = 1<<index.
  - scan_col_data = frame bits [index*COLS +: COLS].
  - In OFF, the scan counters are held at 0 and both scan outputs are 0.

## Timing
- Latency: a command sampled at edge N updates cur_row/cur_col, frame, and moved, all visible after edge N. There is one cycle from button to LED.
- moved is registered. It is high for exactly the cycle following each position change, and never high in OFF or INIT.
- power drop mid-move: the move is discarded and the state is OFF after the next edge.
- Re-entry from OFF always passes through INIT, so the cursor restarts at (0,0).
- reset mid-RUN: the state is OFF after the edge. INIT follows on the next cycle if power=1.
- ROWS/COLS not a power of two: the wrap compares against ROWS-1/COLS-1 explicitly. Never rely on natural counter overflow.
- Repeat counter width is $clog2(max(REPEAT_DLY,REPEAT_RATE)+1). It saturates and never wraps.

## Structure
- Package dot_matrix_pkg holds:
  - state enum (OFF, INIT, RUN)
  - direction encoding constants (DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT over {left,down,right,up})
  - the one-hot validity function
- Sub-module dm_key_repeat contains the command decode, previous-command register, and repeat counter. It outputs a one-cycle step strobe plus the direction.
- The top level holds the FSM, cursor arithmetic, frame decode, and scan counter.

## Test plan
- Default params: reset, power=1, then 3 cycles idle -> state RUN, frame=16'h0001, cur=(0,0), moved=0.
- WRAP=1, cursor (0,0), up held 1 cycle -> cur_row=3, frame bit 12 set, moved high for 1 cycle.
- WRAP=0, cursor (0,3), right held 1 cycle -> cur stays (0,3), moved=0.
- REPEAT_DLY=8, REPEAT_RATE=4, down held 20 cycles from (0,0) -> moves at cycles 0, 8, 12, 16. Row sequence is 1, 2, 3, 0.
- down+right together for 5 cycles -> no movement and moved=0. Then right alone -> immediate move to col+1.
- ROWS=3, COLS=5, SCAN_DIV=2, cursor (2,4) -> scan_row_sel cycles 001, 010, 100 every 2 clk. scan_col_data=5'b10000 only while sel=100. power=0 -> all outputs 0 after the next edge.
